// File: rtl/dsp_counter_scanner_if.sv
// dsp_counter_scanner_if: valid/ready result port of the counter scanner.
// Carries scan_count/scan_chan/scan_valid/scan_done from the scanner and scan_ready back from the consumer.
interface dsp_counter_scanner_if #(parameter int CHW = 3);
  logic [24:0]    scan_count;
  logic [CHW-1:0] scan_chan;
  logic           scan_valid;
  logic           scan_ready;
  logic           scan_done;
  modport master (output scan_count, scan_chan, scan_valid, scan_done, input scan_ready);
  modport slave (input scan_count, scan_chan, scan_valid, scan_done, output scan_ready);
endinterface

// File: rtl/dsp_counter_scanner.sv
// dsp_counter_scanner: round-robin scheduler sharing one acknowledge-mode timed counter across NCHAN inputs.
// Ports: clk, rst (sync, active high), enable, count_in_vec, interval_in/interval_wr (interval register),
// ctr_* (drive/readback of the shared counter), scan (result port: count, chan, valid, ready, done).
module dsp_counter_scanner #(
  parameter int          NCHAN            = 8,
  parameter int          CHW              = 3,
  parameter logic [23:0] INTERVAL_DEFAULT = 24'd1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [NCHAN-1:0] count_in_vec,
  input  logic [23:0]      interval_in,
  input  logic             interval_wr,
  output logic             ctr_count_in,
  output logic [23:0]      ctr_interval_in,
  output logic             ctr_interval_load,
  output logic             ctr_rst,
  input  logic [24:0]      ctr_count_out,
  input  logic             ctr_count_valid,
  dsp_counter_scanner_if.master scan
);
  typedef enum logic [1:0] {IDLE, START, COUNT, HOLD} state_t;
  state_t         state, state_nxt;
  logic [CHW-1:0] chan, chan_nxt;
  logic [23:0]    interval_q;
  logic           pending, armed, capture, hs, last;
  always_comb begin
    hs = scan.scan_valid & scan.scan_ready & (state == HOLD);
    last = chan == CHW'(NCHAN - 1);
    // the counter's detect flag is stale until one cycle after rst/load, so skip the first COUNT cycle
    capture = (state == COUNT) & armed & ctr_count_valid;
    state_nxt = state == IDLE  ? (enable ? START : IDLE) :
                state == START ? COUNT :
                state == COUNT ? (capture ? HOLD : COUNT) :
                hs ? ((last & ~enable) ? IDLE : START) : HOLD;
    chan_nxt = hs ? (last ? '0 : chan + 1'b1) : chan;
    ctr_rst = (state == IDLE) | ((state == START) & ~pending);
    ctr_interval_load = (state == START) & pending;
    ctr_count_in = count_in_vec[chan] & (state == COUNT);
    ctr_interval_in = interval_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      chan <= '0;
      interval_q <= INTERVAL_DEFAULT;
      pending <= 1'b1;
      armed <= 1'b0;
      scan.scan_valid <= 1'b0;
      scan.scan_count <= '0;
      scan.scan_chan <= '0;
      scan.scan_done <= 1'b0;
    end else begin
      state <= state_nxt;
      chan <= chan_nxt;
      interval_q <= interval_wr ? interval_in : interval_q;
      // a write landing on a START cycle keeps pending so the next START reloads the new value
      pending <= interval_wr | (pending & (state != START));
      armed <= state == COUNT;
      scan.scan_count <= capture ? ctr_count_out : scan.scan_count;
      scan.scan_chan <= capture ? chan : scan.scan_chan;
      scan.scan_valid <= capture | (scan.scan_valid & ~hs);
      scan.scan_done <= hs & last;
    end
  end
endmodule

// File: tb/tb_dsp_counter_scanner.sv
// tb_dsp_counter_scanner: scoreboard bench with a behavioural acknowledge-mode counter attached.
module tb_dsp_counter_scanner;
  localparam int NCHAN = 4;
  localparam int CHW = 2;
  logic clk = 0, rst = 1, enable = 0, interval_wr = 0, hold_ready = 0;
  logic [NCHAN-1:0] count_in_vec = '0;
  logic [23:0] interval_in = '0;
  logic ctr_count_in, ctr_interval_load, ctr_rst;
  logic [23:0] ctr_interval_in;
  logic [24:0] ctr_count_out = '0;
  logic ctr_count_valid = 0;
  int checks = 0, errors = 0;
  dsp_counter_scanner_if #(.CHW(CHW)) scan ();
  dsp_counter_scanner #(.NCHAN(NCHAN), .CHW(CHW), .INTERVAL_DEFAULT(24'd1000)) dut (
    .clk(clk), .rst(rst), .enable(enable), .count_in_vec(count_in_vec),
    .interval_in(interval_in), .interval_wr(interval_wr),
    .ctr_count_in(ctr_count_in), .ctr_interval_in(ctr_interval_in),
    .ctr_interval_load(ctr_interval_load), .ctr_rst(ctr_rst),
    .ctr_count_out(ctr_count_out), .ctr_count_valid(ctr_count_valid), .scan(scan));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  // counter: counts count_in for interval clocks after rst/load, then holds count and valid until acknowledged
  logic [23:0] c_iv = '0;
  logic [24:0] c_cnt = '0, c_tmr = '0;
  always @(posedge clk) begin
    if (rst || ctr_rst || ctr_interval_load) begin
      c_cnt <= '0;
      c_tmr <= '0;
      ctr_count_valid <= 1'b0;
      if (ctr_interval_load) c_iv <= ctr_interval_in;
    end else if (!ctr_count_valid) begin
      c_cnt <= c_cnt + 25'(ctr_count_in);
      c_tmr <= c_tmr + 25'd1;
      if (c_tmr + 25'd1 == (c_iv == 0 ? 25'h1000000 : {1'b0, c_iv})) begin
        ctr_count_valid <= 1'b1;
        ctr_count_out <= c_cnt + 25'(ctr_count_in);
      end
    end
  end
  typedef struct packed {logic [CHW-1:0] ch; logic [24:0] cnt; logic last;} exp_t;
  exp_t q[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  initial begin
    scan.scan_ready = 0;
    forever begin
      @(posedge clk);
      #1 scan.scan_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end
  bit stalled = 0, done_chk = 0, done_exp = 0;
  logic [24:0] s_cnt;
  logic [CHW-1:0] s_ch;
  exp_t e;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 0;
      done_chk = 0;
    end else begin
      if (done_chk) chk("scan_done", scan.scan_done, done_exp);
      else if (scan.scan_done) chk("scan_done_spurious", scan.scan_done, 0);
      done_chk = 0;
      if (stalled) begin
        chk("stall_valid", scan.scan_valid, 1);
        chk("stall_count", scan.scan_count, s_cnt);
        chk("stall_chan", scan.scan_chan, s_ch);
      end
      stalled = 0;
      if (scan.scan_valid) chk("hold_ctr_rst_load", {ctr_rst, ctr_interval_load}, 0);
      if (scan.scan_valid && !scan.scan_ready) begin
        stalled = 1;
        s_cnt = scan.scan_count;
        s_ch = scan.scan_chan;
      end
      if (scan.scan_valid && scan.scan_ready) begin
        if (q.size() == 0) chk("unexpected_result_chan", scan.scan_chan, 32'hffff);
        else begin
          e = q.pop_front();
          chk("result_chan", scan.scan_chan, e.ch);
          chk("result_count", scan.scan_count, e.cnt);
          done_chk = 1;
          done_exp = e.last;
        end
      end
    end
  end
  int unsigned win_now = 1000;
  bit pend = 1;
  int ch_b = 0;
  task automatic do_start(input logic [NCHAN-1:0] p);
    count_in_vec = p;
    chk("start_load", ctr_interval_load, pend);
    chk("start_rst", ctr_rst, !pend);
    if (pend) chk("start_interval", ctr_interval_in, win_now);
    q.push_back('{ch: CHW'(ch_b), cnt: (p[ch_b] ? 25'(win_now) : 25'd0), last: (ch_b == NCHAN - 1)});
    pend = 0;
    ch_b = (ch_b + 1) % NCHAN;
  endtask
  task automatic wr(input logic [23:0] v);
    interval_in = v;
    interval_wr = 1;
    @(posedge clk);
    #1 interval_wr = 0;
    win_now = v;
    pend = 1;
  endtask
  task automatic wait_hs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(scan.scan_valid && scan.scan_ready) && n < 5000);
    if (n >= 5000) chk("handshake_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!scan.scan_valid && n < 5000);
    if (n >= 5000) chk("valid_timeout", 0, 1);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", scan.scan_valid, 0);
    chk("rst_chan", scan.scan_chan, 0);
    chk("rst_count", scan.scan_count, 0);
    chk("rst_done", scan.scan_done, 0);
    chk("rst_ctr_rst", ctr_rst, 1);
    chk("rst_interval", ctr_interval_in, 1000);
    chk("rst_load", ctr_interval_load, 0);
    rst = 0;
    @(posedge clk);
    #1 wr(24'd10);
    chk("idle_interval", ctr_interval_in, 10);
    chk("idle_ctr_rst", ctr_rst, 1);
    enable = 1;
    @(posedge clk);
    #1;
    for (int c = 0; c < NCHAN; c++) begin
      do_start(4'b0100);
      wait_hs();
    end
    do_start(4'b0110);
    wait_hs();
    do_start(4'b0110);
    hold_ready = 1;
    @(posedge clk);
    #1 wr(24'd20);
    wait_valid();
    repeat (50) @(posedge clk);
    #1 hold_ready = 0;
    wait_hs();
    do_start(4'b0110);
    wait_hs();
    do_start(4'b1000);
    @(posedge clk);
    #1 wr(24'd12);
    wait_hs();
    do_start(4'b0001);
    wr(24'd15);
    wait_hs();
    do_start(4'b0010);
    enable = 0;
    wait_hs();
    do_start(4'b0100);
    wait_hs();
    do_start(4'b1000);
    wait_hs();
    chk("idle_after_sweep_rst", ctr_rst, 1);
    chk("idle_after_sweep_load", ctr_interval_load, 0);
    repeat (30) @(posedge clk);
    #1;
    chk("idle_quiet_valid", scan.scan_valid, 0);
    chk("idle_quiet_rst", ctr_rst, 1);
    enable = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 24; i++) begin
      int r;
      do_start(NCHAN'($urandom));
      if (i == 20) enable = 0;
      r = $urandom_range(0, 2);
      if (r == 1) wr(24'($urandom_range(2, 30)));
      else if (r == 2) begin
        @(posedge clk);
        #1 wr(24'($urandom_range(2, 30)));
      end
      wait_hs();
    end
    enable = 1;
    @(posedge clk);
    #1 do_start(4'b1111);
    wait_hs();
    do_start(4'b1111);
    hold_ready = 1;
    wait_valid();
    repeat (3) @(posedge clk);
    #1;
    enable = 0;
    rst = 1;
    @(posedge clk);
    #1;
    chk("midrst_valid", scan.scan_valid, 0);
    chk("midrst_chan", scan.scan_chan, 0);
    chk("midrst_count", scan.scan_count, 0);
    chk("midrst_ctr_rst", ctr_rst, 1);
    chk("midrst_interval", ctr_interval_in, 1000);
    q.delete();
    rst = 0;
    hold_ready = 0;
    win_now = 1000;
    pend = 1;
    ch_b = 0;
    enable = 1;
    @(posedge clk);
    #1 do_start(4'b1001);
    enable = 0;
    wait_hs();
    for (int c = 1; c < NCHAN; c++) begin
      do_start(4'b1001);
      wait_hs();
    end
    repeat (5) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
